// File: rtl/axi4_slave_mem_pkg.sv
// Shared AXI4 types: burst encoding, response codes, engine states
// and the per-beat address step used by the slave memory.
package pkg_Axi4Types;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  function automatic logic [31:0] next_beat_addr(
    input logic [31:0] addr,
    input logic [2:0]  size,
    input logic [7:0]  len,
    input burst_e      burst
  );
    logic [31:0] inc;
    logic [31:0] wrap;
    logic [31:0] res;
    inc  = 32'd1 << size;
    wrap = ({24'd0, len} + 32'd1) << size;
    case (burst)
      BURST_INCR: res = (addr & ~(inc - 32'd1)) + inc;
      BURST_WRAP: res = (addr & ~(wrap - 32'd1)) |
                        ((addr + inc) & (wrap - 32'd1));
      default:    res = addr;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/axi4_slave_mem_addr_gen.sv
// Beat address, beat counter and sticky error flag for one
// burst engine; loaded on the address handshake.
module axi4_slave_addr_gen
  import pkg_Axi4Types::*;
#(
  parameter int N         = 8,
  parameter int MEM_BYTES = 65536,
  localparam int IW = $clog2(MEM_BYTES) - $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [31:0]   addr_i,
  input  logic [7:0]    len_i,
  input  logic [2:0]    size_i,
  input  logic [1:0]    burst_i,
  input  logic          adv_i,
  input  logic          set_err_i,
  output logic [IW-1:0] idx_o,
  output logic [IW-1:0] nidx_o,
  output logic          last_o,
  output logic          err_o
);

  localparam int LOG_N = $clog2(N);
  localparam int AW    = $clog2(MEM_BYTES);

  logic [31:0] beat_q, beat_d, nxt;
  logic [7:0]  len_q, len_d, cnt_q, cnt_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic        err_q, err_d;
  logic        bad;
  logic [31:0] inc_i;

  assign inc_i = 32'd1 << size_i;

  always_comb begin
    bad = 1'b0;
    if (burst_i == 2'd3)
      bad = 1'b1;
    if (burst_i == 2'd2 &&
        !(len_i inside {8'd1, 8'd3, 8'd7, 8'd15}))
      bad = 1'b1;
    if (burst_i == 2'd2 && (addr_i & (inc_i - 32'd1)) != 32'd0)
      bad = 1'b1;
    if (int'(size_i) > LOG_N)
      bad = 1'b1;
    if (addr_i >= 32'(MEM_BYTES))
      bad = 1'b1;
  end

  assign nxt    = next_beat_addr(beat_q, size_q, len_q,
                                 burst_e'(burst_q));
  assign last_o = cnt_q == len_q;
  assign err_o  = err_q;
  assign idx_o  = beat_q[AW-1:LOG_N];
  assign nidx_o = nxt[AW-1:LOG_N];

  // the step past the final beat is never accessed, so it cannot fault
  always_comb begin
    beat_d  = beat_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (start_i) begin
      beat_d  = addr_i;
      len_d   = len_i;
      size_d  = size_i;
      burst_d = burst_i;
      cnt_d   = 8'd0;
      err_d   = bad;
    end else if (adv_i) begin
      beat_d = nxt;
      cnt_d  = cnt_q + 8'd1;
      err_d  = err_q | set_err_i |
               (!last_o && nxt >= 32'(MEM_BYTES));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      beat_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      beat_q  <= beat_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory: independent single-outstanding read and
// write engines over a word-organised, byte-writable array.
module axi4_slave_mem
  import pkg_Axi4Types::*;
#(
  parameter int N         = 8,
  parameter int I         = 8,
  parameter int MEM_BYTES = 65536
) (
  input  logic           ACLK,
  input  logic           ARESETn,
  input  logic [I-1:0]   AWID,
  input  logic [31:0]    AWADDR,
  input  logic [7:0]     AWLEN,
  input  logic [2:0]     AWSIZE,
  input  logic [1:0]     AWBURST,
  input  logic           AWLOCK,
  input  logic [3:0]     AWCACHE,
  input  logic [2:0]     AWPROT,
  input  logic [3:0]     AWQOS,
  input  logic [3:0]     AWREGION,
  input  logic           AWVALID,
  output logic           AWREADY,
  input  logic [8*N-1:0] WDATA,
  input  logic [N-1:0]   WSTRB,
  input  logic           WLAST,
  input  logic           WVALID,
  output logic           WREADY,
  output logic [I-1:0]   BID,
  output logic [1:0]     BRESP,
  output logic           BVALID,
  input  logic           BREADY,
  input  logic [I-1:0]   ARID,
  input  logic [31:0]    ARADDR,
  input  logic [7:0]     ARLEN,
  input  logic [2:0]     ARSIZE,
  input  logic [1:0]     ARBURST,
  input  logic           ARLOCK,
  input  logic [3:0]     ARCACHE,
  input  logic [2:0]     ARPROT,
  input  logic [3:0]     ARQOS,
  input  logic [3:0]     ARREGION,
  input  logic           ARVALID,
  output logic           ARREADY,
  output logic [I-1:0]   RID,
  output logic [8*N-1:0] RDATA,
  output logic [1:0]     RRESP,
  output logic           RLAST,
  output logic           RVALID,
  input  logic           RREADY
);

  localparam int LOG_N = $clog2(N);
  localparam int AW    = $clog2(MEM_BYTES);
  localparam int IW    = AW - LOG_N;
  localparam int DEPTH = MEM_BYTES / N;

  w_state_e       w_q, w_d;
  r_state_e       r_q, r_d;
  logic           rst_done_q;
  logic [I-1:0]   wid_q, rid_q;
  logic           aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic [IW-1:0]  w_idx, w_nidx_unused, r_idx_unused, r_nidx;
  logic           w_last, w_err, r_last, r_err, wlast_bad;
  logic [8*N-1:0] mem_q [DEPTH];
  logic [8*N-1:0] rdata_q;
  logic           unused_ok;

  assign unused_ok = ^{AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION,
                       ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION,
                       w_nidx_unused, r_idx_unused};

  assign aw_fire   = ARESETn && AWVALID && AWREADY;
  assign w_fire    = ARESETn && WVALID && WREADY;
  assign b_fire    = ARESETn && BVALID && BREADY;
  assign ar_fire   = ARESETn && ARVALID && ARREADY;
  assign r_fire    = ARESETn && RVALID && RREADY;
  assign wlast_bad = w_fire && (WLAST != w_last);

  axi4_slave_addr_gen #(.N(N), .MEM_BYTES(MEM_BYTES)) u_wgen (
    .clk_i(ACLK), .rst_ni(ARESETn), .start_i(aw_fire),
    .addr_i(AWADDR), .len_i(AWLEN), .size_i(AWSIZE),
    .burst_i(AWBURST), .adv_i(w_fire), .set_err_i(wlast_bad),
    .idx_o(w_idx), .nidx_o(w_nidx_unused),
    .last_o(w_last), .err_o(w_err)
  );

  axi4_slave_addr_gen #(.N(N), .MEM_BYTES(MEM_BYTES)) u_rgen (
    .clk_i(ACLK), .rst_ni(ARESETn), .start_i(ar_fire),
    .addr_i(ARADDR), .len_i(ARLEN), .size_i(ARSIZE),
    .burst_i(ARBURST), .adv_i(r_fire), .set_err_i(1'b0),
    .idx_o(r_idx_unused), .nidx_o(r_nidx),
    .last_o(r_last), .err_o(r_err)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      w_q        <= W_IDLE;
      r_q        <= R_IDLE;
      rst_done_q <= 1'b0;
      wid_q      <= '0;
      rid_q      <= '0;
    end else begin
      w_q        <= w_d;
      r_q        <= r_d;
      rst_done_q <= 1'b1;
      if (aw_fire) wid_q <= AWID;
      if (ar_fire) rid_q <= ARID;
    end
  end

  always_comb begin
    w_d = w_q;
    case (w_q)
      W_IDLE:  if (aw_fire) w_d = W_DATA;
      W_DATA:  if (w_fire && w_last) w_d = W_RESP;
      W_RESP:  if (b_fire) w_d = W_IDLE;
      default: w_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_d = r_q;
    case (r_q)
      R_IDLE:  if (ar_fire) r_d = R_DATA;
      R_DATA:  if (r_fire && r_last) r_d = R_IDLE;
      default: r_d = R_IDLE;
    endcase
  end

  always_comb begin
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    case (w_q)
      W_IDLE:  AWREADY = rst_done_q;
      W_DATA:  WREADY  = 1'b1;
      W_RESP:  BVALID  = 1'b1;
      default: ;
    endcase
    case (r_q)
      R_IDLE:  ARREADY = rst_done_q;
      R_DATA:  RVALID  = 1'b1;
      default: ;
    endcase
  end

  assign BID   = BVALID ? wid_q : '0;
  assign BRESP = (BVALID && w_err) ? RESP_SLVERR : RESP_OKAY;
  assign RID   = RVALID ? rid_q : '0;
  assign RDATA = (RVALID && !r_err) ? rdata_q : '0;
  assign RRESP = (RVALID && r_err) ? RESP_SLVERR : RESP_OKAY;
  assign RLAST = RVALID && r_last;

  // read port prefetches the next beat so each R beat is registered
  always_ff @(posedge ACLK) begin
    if (w_fire && !w_err)
      for (int l = 0; l < N; l++)
        if (WSTRB[l]) mem_q[w_idx][8*l +: 8] <= WDATA[8*l +: 8];
    if (ar_fire)
      rdata_q <= mem_q[ARADDR[AW-1:LOG_N]];
    else if (r_fire && !r_last)
      rdata_q <= mem_q[r_nidx];
  end

endmodule

// File: doc/axi4_slave_mem.md
# axi4_slave_mem

Synthesizable AXI4 slave memory that answers transactions issued by `Axi4MasterBFM` over the `AXI4 #(N, I)` interface. It is the downstream target in the top-level bench. It has independent read and write engines, each with one outstanding transaction, over a byte-addressed internal array. It supports FIXED, INCR and WRAP bursts and returns SLVERR for illegal or out-of-range accesses.

## Interface
Parameters:
- `N`, 8: data bus width in bytes; must be a power of two.
- `I`, 8: ID width in bits.
- `MEM_BYTES`, 65536: memory size in bytes; must be a power of two and a multiple of N.

Ports:
- `ACLK` in 1: single clock; all logic is on the rising edge.
- `ARESETn` in 1: reset, synchronous and active-low.
- `AWID`, `AWADDR`, `AWLEN`, `AWSIZE`, `AWBURST` in I/32/8/3/2: write address payload.
- `AWVALID` in 1, `AWREADY` out 1: write address handshake.
- `WDATA`, `WSTRB`, `WLAST` in 8N/N/1: write data payload.
- `WVALID` in 1, `WREADY` out 1: write data handshake.
- `BID`, `BRESP` out I/2: write response payload.
- `BVALID` out 1, `BREADY` in 1: write response handshake.
- `ARID`, `ARADDR`, `ARLEN`, `ARSIZE`, `ARBURST` in I/32/8/3/2: read address payload.
- `ARVALID` in 1, `ARREADY` out 1: read address handshake.
- `RID`, `RDATA`, `RRESP`, `RLAST` out I/8N/2/1: read data payload.
- `RVALID` out 1, `RREADY` in 1: read data handshake.
- `AW/ARLOCK`, `CACHE`, `PROT`, `QOS`, `REGION` in: accepted and ignored.

## Operation
- **Reset.** While `ARESETn` is sampled low, every output is 0 and both engines go to IDLE. Reset aborts any burst in flight; its response is never issued. Memory contents are not cleared.
- **Write FSM: W_IDLE → W_DATA → W_RESP → W_IDLE.**
  - W_IDLE: `AWREADY=1`. On an AW handshake, latch ID, address, len, size and burst, compute the error flag, then go to W_DATA.
  - W_DATA: `WREADY=1`. Each W handshake writes the bytes whose `WSTRB` bit is set to byte address `(beat_addr & ~(N-1)) + lane`. No write happens if the error flag is set. The beat address then advances.
  - A beat counter counts up to `AWLEN`. The handshake on beat `AWLEN` moves the FSM to W_RESP regardless of `WLAST`.
  - If `WLAST` does not match (early or missing on the final beat), the error flag is set and BRESP becomes SLVERR.
  - W_RESP: `BVALID=1`, `BID`=latched ID, `BRESP`=OKAY(0) or SLVERR(2). Hold until `BREADY`, then go to W_IDLE.
- **Read FSM: R_IDLE → R_DATA → R_IDLE.**
  - R_IDLE: `ARREADY=1`. On an AR handshake, latch the request and go to R_DATA.
  - R_DATA: `RVALID=1` with the full aligned N-byte word at the beat address. `RDATA=0` when the error flag is set.
  - `RLAST=1` on beat `ARLEN`. `RRESP` is the same on every beat.
  - Payload stays stable while `RVALID && !RREADY`. After the handshake on the last beat, go to R_IDLE.
- **Address generation** (beat address B, size S, len L):
  - FIXED (0): B unchanged.
  - INCR (1): B = aligned(B) + 2^S.
  - WRAP (2): boundary W = (L+1)·2^S; B = (B & ~(W-1)) | ((B + 2^S) & (W-1)).
- **Error flag (SLVERR)** is set on any of:
  - burst = 3;
  - WRAP with L ∉ {1,3,7,15};
  - WRAP with an unaligned start address;
  - 2^S > N;
  - any beat address ≥ MEM_BYTES, evaluated per beat and sticky for the rest of the burst.
- **Arbitration.** The read and write engines run fully in parallel. A same-cycle read and write to the same address returns the old data.

## Timing
- `AWREADY`/`ARREADY` rise one cycle after `ARESETn` is released.
- AW handshake in cycle t → `WREADY=1` from t+1. Final W handshake in t → `BVALID=1` at t+1.
- AR handshake in t → first `RVALID` at t+1, because the array read is registered. Back-to-back beats give 1 beat/cycle with `RREADY` held high.
- After the last R or B handshake at t, the matching ready is high again at t+1.
- With no backpressure, a single-beat write takes 3 cycles from AW handshake to B handshake; a single-beat read takes 2 cycles from AR handshake to R handshake.

## Structure
- Add to `pkg_Axi4Types`:
  - burst enum (FIXED/INCR/WRAP);
  - response constants (OKAY=0, SLVERR=2);
  - function `next_beat_addr(addr, size, len, burst)`.
- Sub-module `axi4_slave_addr_gen`: holds the beat counter, beat address, last-beat flag and error detection. It is instantiated once per engine.
- The memory array and both FSMs live in `axi4_slave_mem`.

## Test plan
- **Reset.** Outputs are all 0 while `ARESETn` is low; `AWREADY=ARREADY=1` one cycle after release.
- **Single write then read.**
  - Write at 0x2000, len 0, size 3, data 0xDEADBEEF12345678, strb 0xFF → BRESP=0, BID=0.
  - Read at 0x2000 → RDATA 0xDEADBEEF12345678, RLAST=1, RRESP=0, RVALID one cycle after the AR handshake.
- **INCR burst with backpressure.**
  - Write 4 beats at 0x1000, then read them back with `RREADY` toggled every cycle.
  - Each RDATA is held until accepted; RLAST only on beat 3.
- **WRAP and strobes.**
  - WRAP len 3, size 3, starting at 0x1010 → beats hit 0x1010, 0x1018, 0x1000, 0x1008.
  - A write with strb 0x0F changes only the low 4 bytes.
- **Errors.**
  - Read at 0x10000 → RRESP=2 and RDATA=0.
  - Burst=3 write → BRESP=2 and memory unchanged.
  - WLAST early on beat 1 of a 4-beat burst → BRESP=2.
- **Concurrency and reset mid-burst.**
  - Read and write in flight together with distinct IDs → each response carries its own ID.
  - Reset during beat 2 of an 8-beat read → RVALID=0 next cycle and no further beats.
